// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   ZERO_WORD      : value driven on the instruction bus when nothing is valid
//   fetch_state_e  : fetch FSM encoding (RUN issues, DRAIN drops stale responses)
//   fetch_entry_t  : one response-buffer entry {pc, inst}
//   word_align()   : clears the byte-offset bits of an address
package if_fetch_unit_pkg;

  localparam logic [31:0] ZERO_WORD = '0;

  typedef enum logic {
    FETCH_RUN   = 1'b0,
    FETCH_DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_fetch_unit_fifo.sv
// Response buffer between instruction memory and the IF/ID register.
// Synchronous FIFO of {pc, inst} entries; the head is read combinationally,
// so an entry written on one edge is visible in the following cycle.
//   clk, rst : clock, synchronous active-high reset
//   push/din : write an entry (ignored when full or flushing)
//   pop/dout : release the head entry (ignored when empty or flushing)
//   flush    : discard all contents; overrides push and pop
//   full, empty, count : occupancy status
module if_fetch_fifo
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     din,
  output fetch_entry_t     dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && !full && !flush;
    do_pop   = pop && !empty && !flush;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only observed through count/empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage. Owns the fetch PC, issues word reads to imem,
// buffers in-order responses and presents {pc_o, if_inst} to IF/ID.
//   clk, rst                  : clock, synchronous active-high reset
//   imem_req/addr/gnt         : request handshake (addr held while !gnt)
//   imem_rvalid/rdata         : in-order read responses
//   id_stall                  : IF/ID holding; head is not consumed
//   branch_en/branch_target   : redirect, highest priority
//   if_valid/if_inst/pc_o     : buffered instruction, zero when not valid
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        branch_en,
  input  logic [31:0] branch_target,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] pc_o
);

  fetch_state_e     state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] discard_q, discard_d;

  logic [CNT_W-1:0] fifo_cnt;
  logic             fifo_full, fifo_empty;
  fetch_entry_t     fifo_head, fifo_din;
  logic [CNT_W:0]   credit_used;
  logic             issue, drop, resp_push, pop;

  // Credits cover both in-flight and buffered entries, so a response can never
  // find the buffer full.
  assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_cnt};
  assign issue       = imem_req && imem_gnt;
  assign drop        = imem_rvalid && (discard_q != '0);
  assign resp_push   = imem_rvalid && !drop && !branch_en;
  assign pop         = if_valid && !id_stall && !branch_en;
  assign fifo_din    = '{pc: resp_pc_q, inst: imem_rdata};

  assign imem_addr = fetch_pc_q;
  assign if_valid  = !fifo_empty;
  assign if_inst   = if_valid ? fifo_head.inst : ZERO_WORD;
  assign pc_o      = if_valid ? fifo_head.pc : ZERO_WORD;

  // Datapath: PCs and counters.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(imem_rvalid);
    discard_d     = discard_q - CNT_W'(drop);
    if (branch_en) begin
      // Every request still outstanding after this cycle belongs to the old path.
      discard_d  = outstanding_d;
      fetch_pc_d = word_align(branch_target);
      resp_pc_d  = word_align(branch_target);
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + 32'd4;
      if (resp_push && !fifo_full) resp_pc_d = resp_pc_q + 32'd4;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    if (branch_en) begin
      state_d = (discard_d != '0) ? FETCH_DRAIN : FETCH_RUN;
    end else if (state_q == FETCH_DRAIN && discard_d == '0) begin
      state_d = FETCH_RUN;
    end
  end

  // FSM output.
  always_comb begin
    imem_req = !rst && (state_q == FETCH_RUN) && !branch_en &&
               (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH_RUN;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  if_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (resp_push),
    .pop   (pop),
    .flush (branch_en),
    .din   (fifo_din),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit. The imem model grants per the bench's
// gnt input and returns inst = ~addr a fixed number of cycles after grant.
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        branch_en;
  logic [31:0] branch_target;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] pc_o;

  int n_checks = 0;
  int n_fail   = 0;
  int lat      = 1;

  if_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .id_stall      (id_stall),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .if_valid      (if_valid),
    .if_inst       (if_inst),
    .pc_o          (pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: fixed-latency in-order pipeline, cleared by the shared reset.
  logic [7:0]  pv;
  logic [31:0] pa [8];
  always @(posedge clk) begin
    if (rst) begin
      pv <= '0;
    end else begin
      pv    <= {pv[6:0], imem_req && imem_gnt};
      pa[0] <= imem_addr;
      for (int i = 1; i < 8; i++) pa[i] <= pa[i-1];
    end
  end
  assign imem_rvalid = pv[lat-1];
  assign imem_rdata  = pv[lat-1] ? ~pa[lat-1] : 32'h0;

  typedef struct {
    logic        rst, gnt, stall, br;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc, inst;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic g, input logic s,
                       input logic b, input logic [31:0] t);
    rst = r; imem_gnt = g; id_stall = s; branch_en = b; branch_target = t;
    #1;
    chk("no_push_when_full", {31'b0, dut.u_fifo.push && dut.u_fifo.full}, 32'h0);
    chk("no_outstanding_underflow", {31'b0, imem_rvalid && (dut.outstanding_q == '0)}, 32'h0);
  endtask

  task automatic outs(input string p, input logic req, input logic [31:0] addr,
                      input logic valid, input logic [31:0] pc, input logic [31:0] inst);
    chk({p, ".imem_req"}, {31'b0, imem_req}, {31'b0, req});
    chk({p, ".imem_addr"}, imem_addr, addr);
    chk({p, ".if_valid"}, {31'b0, if_valid}, {31'b0, valid});
    chk({p, ".pc_o"}, pc_o, pc);
    chk({p, ".if_inst"}, if_inst, inst);
  endtask

  task automatic do_reset();
    apply(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
  endtask

  int issues;

  initial begin
    // Reset row, back-to-back fetch, then gnt low for three cycles at 0x10.
    tbl[0]  = '{1, 1, 0, 0, 0, 0, 32'h00, 0, 32'h00, 32'h0};
    tbl[1]  = '{0, 1, 0, 0, 0, 1, 32'h00, 0, 32'h00, 32'h0};
    tbl[2]  = '{0, 1, 0, 0, 0, 1, 32'h04, 0, 32'h00, 32'h0};
    tbl[3]  = '{0, 1, 0, 0, 0, 1, 32'h08, 1, 32'h00, 32'hFFFF_FFFF};
    tbl[4]  = '{0, 1, 0, 0, 0, 1, 32'h0C, 1, 32'h04, 32'hFFFF_FFFB};
    tbl[5]  = '{0, 0, 0, 0, 0, 1, 32'h10, 1, 32'h08, 32'hFFFF_FFF7};
    tbl[6]  = '{0, 0, 0, 0, 0, 1, 32'h10, 1, 32'h0C, 32'hFFFF_FFF3};
    tbl[7]  = '{0, 0, 0, 0, 0, 1, 32'h10, 0, 32'h00, 32'h0};
    tbl[8]  = '{0, 1, 0, 0, 0, 1, 32'h10, 0, 32'h00, 32'h0};
    tbl[9]  = '{0, 1, 0, 0, 0, 1, 32'h14, 0, 32'h00, 32'h0};
    tbl[10] = '{0, 1, 0, 0, 0, 1, 32'h18, 1, 32'h10, 32'hFFFF_FFEF};

    lat = 1;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      apply(tbl[i].rst, tbl[i].gnt, tbl[i].stall, tbl[i].br, tbl[i].tgt);
      outs($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].valid,
           tbl[i].pc, tbl[i].inst);
      @(negedge clk);
    end

    // Stall for 10 cycles: credits allow exactly four requests.
    do_reset();
    issues = 0;
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      if (imem_req && imem_gnt) issues++;
      @(negedge clk);
    end
    apply(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("stall.issue_count", issues, 32'd4);
    outs("stall.held", 1'b0, 32'h10, 1'b1, 32'h0, 32'hFFFF_FFFF);
    @(negedge clk);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    outs("stall.rel0", 1'b0, 32'h10, 1'b1, 32'h0, 32'hFFFF_FFFF);
    @(negedge clk);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    outs("stall.rel1", 1'b1, 32'h10, 1'b1, 32'h4, 32'hFFFF_FFFB);
    @(negedge clk);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    outs("stall.rel2", 1'b1, 32'h14, 1'b1, 32'h8, 32'hFFFF_FFF7);
    @(negedge clk);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    outs("stall.rel3", 1'b1, 32'h18, 1'b1, 32'hC, 32'hFFFF_FFF3);
    @(negedge clk);

    // Redirect to 0x103 with two requests in flight (3-cycle memory).
    lat = 3;
    do_reset();
    apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    outs("redir.c0", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    outs("redir.c1", 1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    apply(1'b0, 1'b1, 1'b0, 1'b1, 32'h103);
    chk("redir.c2.imem_req", {31'b0, imem_req}, 32'h0);
    @(negedge clk);
    for (int i = 3; i < 5; i++) begin
      apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      chk($sformatf("redir.c%0d.drain", i), {31'b0, dut.state_q == FETCH_DRAIN}, 32'h1);
      chk($sformatf("redir.c%0d.stale_rvalid", i), {31'b0, imem_rvalid}, 32'h1);
      outs($sformatf("redir.c%0d", i), 1'b0, 32'h100, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
    end
    apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("redir.c5.run", {31'b0, dut.state_q == FETCH_RUN}, 32'h1);
    outs("redir.c5", 1'b1, 32'h100, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    for (int i = 6; i < 9; i++) begin
      apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      chk($sformatf("redir.c%0d.if_valid", i), {31'b0, if_valid}, 32'h0);
      chk($sformatf("redir.c%0d.pc_o", i), pc_o, 32'h0);
      @(negedge clk);
    end
    apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("redir.c9.if_valid", {31'b0, if_valid}, 32'h1);
    chk("redir.c9.pc_o", pc_o, 32'h100);
    chk("redir.c9.if_inst", if_inst, 32'hFFFF_FEFF);
    @(negedge clk);

    // Redirect coinciding with rvalid and a pop.
    lat = 1;
    do_reset();
    apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    apply(1'b0, 1'b1, 1'b0, 1'b1, 32'h200);
    chk("same.c2.rvalid", {31'b0, imem_rvalid}, 32'h1);
    outs("same.c2", 1'b0, 32'h8, 1'b1, 32'h0, 32'hFFFF_FFFF);
    @(negedge clk);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("same.c3.run", {31'b0, dut.state_q == FETCH_RUN}, 32'h1);
    outs("same.c3", 1'b1, 32'h200, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    outs("same.c4", 1'b1, 32'h204, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    outs("same.c5", 1'b1, 32'h208, 1'b1, 32'h200, 32'hFFFF_FDFF);
    @(negedge clk);

    // Address wrap at the top of memory, then reset mid-stream.
    do_reset();
    apply(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
    chk("wrap.c0.imem_req", {31'b0, imem_req}, 32'h0);
    @(negedge clk);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    outs("wrap.c1", 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    outs("wrap.c2", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    outs("wrap.c3", 1'b1, 32'h0, 1'b1, 32'hFFFF_FFF8, 32'h0000_0007);
    @(negedge clk);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    outs("wrap.c4", 1'b1, 32'h4, 1'b1, 32'hFFFF_FFFC, 32'h0000_0003);
    @(negedge clk);
    apply(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("wrap.c5.imem_req", {31'b0, imem_req}, 32'h0);
    @(negedge clk);
    apply(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    outs("wrap.c6", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    outs("wrap.c7", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    outs("wrap.c8", 1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    outs("wrap.c9", 1'b1, 32'h8, 1'b1, 32'h0, 32'hFFFF_FFFF);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
